mem_client_port: RTL and testbench

Client-side endpoint of the shared-memory arbitration protocol, instantiated once per drawing engine (line drawer, circle drawer, fill-rect) between the engine and the memory arbiter. It queues the engine's memory requests, presents them to the arbiter with rts/op/addr/wrdata, and tracks outstanding responses. It also picks this client's read data off the arbiter's broadcast bus and returns it to the engine with the matching address.

---
 rtl/mem_client_port.sv | 158 +++++++++++++++
 tb/tb_mem_client_port.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_client_port.sv
// Client-side endpoint of the shared-memory arbitration protocol: queues engine
// requests for the arbiter and routes this client's broadcast read data back.
module mem_client_port #(
    parameter int CLIENT_ID   = 1,
    parameter int NUM_CLIENTS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_OUT     = 4
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [16:0]            req_addr,
    input  logic [31:0]            req_wrdata,
    input  logic [3:0]             req_op,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_data,
    output logic [16:0]            rsp_addr,
    output logic                   arb_rts,
    input  logic                   arb_rtr,
    output logic [16:0]            arb_addr,
    output logic [31:0]            arb_wrdata,
    output logic [3:0]             arb_op,
    input  logic [31:0]            bcast_data,
    input  logic [NUM_CLIENTS-1:0] bcast_xfc,
    output logic                   idle,
    output logic                   err_unexpected
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(MAX_OUT);
    localparam int OW = TW + 1;
    localparam logic [3:0] OP_FULL_WRITE = 4'b1111;

    logic [16:0]   fifoAddr_q [FIFO_DEPTH];
    logic [31:0]   fifoData_q [FIFO_DEPTH];
    logic [3:0]    fifoOp_q   [FIFO_DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic [16:0]   tagAddr_q [MAX_OUT];
    logic [TW-1:0] tagRd_q, tagRd_d;
    logic [TW-1:0] tagWr_q, tagWr_d;
    logic [OW-1:0] outCnt_q, outCnt_d;

    logic          rspValid_q, rspValid_d;
    logic [31:0]   rspData_q, rspData_d;
    logic [16:0]   rspAddr_q, rspAddr_d;
    logic          errUnexp_q, errUnexp_d;

    logic          empty, full, atLimit, headWantsRsp;
    logic          push, xfer, tagPush, tagPop, rspHit;
    logic [16:0]   headAddr;
    logic [31:0]   headData;
    logic [3:0]    headOp;
    logic          unusedXfcBits;

    function automatic logic [PW-1:0] incFifoPtr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [TW-1:0] incTagPtr(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    // Only this client's bit of the broadcast vector matters; the rest are consumed here.
    assign unusedXfcBits = ^bcast_xfc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign headAddr     = fifoAddr_q[rdPtr_q];
    assign headData     = fifoData_q[rdPtr_q];
    assign headOp       = fifoOp_q[rdPtr_q];
    assign headWantsRsp = (headOp != OP_FULL_WRITE);
    assign atLimit      = (outCnt_q == OW'(MAX_OUT));

    // Full writes may still go out when the response window is saturated.
    assign arb_rts    = !empty && !(headWantsRsp && atLimit);
    assign arb_addr   = empty ? '0 : headAddr;
    assign arb_wrdata = empty ? '0 : headData;
    assign arb_op     = empty ? '0 : headOp;

    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign xfer      = arb_rts && arb_rtr;
    assign tagPush   = xfer && headWantsRsp;
    assign rspHit    = bcast_xfc[CLIENT_ID];
    assign tagPop    = rspHit && (outCnt_q != '0);

    assign idle           = empty && (outCnt_q == '0);
    assign rsp_valid      = rspValid_q;
    assign rsp_data       = rspData_q;
    assign rsp_addr       = rspAddr_q;
    assign err_unexpected = errUnexp_q;

    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        tagRd_d    = tagRd_q;
        tagWr_d    = tagWr_q;
        count_d    = count_q + CW'(push) - CW'(xfer);
        outCnt_d   = outCnt_q + OW'(tagPush) - OW'(tagPop);
        rspValid_d = tagPop;
        rspData_d  = rspData_q;
        rspAddr_d  = rspAddr_q;
        errUnexp_d = errUnexp_q || (rspHit && (outCnt_q == '0));

        if (push)    wrPtr_d = incFifoPtr(wrPtr_q);
        if (xfer)    rdPtr_d = incFifoPtr(rdPtr_q);
        if (tagPush) tagWr_d = incTagPtr(tagWr_q);
        // Responses come back in transfer order, so the tag head names this one.
        if (tagPop) begin
            tagRd_d   = incTagPtr(tagRd_q);
            rspData_d = bcast_data;
            rspAddr_d = tagAddr_q[tagRd_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= req_addr;
            fifoData_q[wrPtr_q] <= req_wrdata;
            fifoOp_q[wrPtr_q]   <= req_op;
        end
        if (tagPush) begin
            tagAddr_q[tagWr_q] <= headAddr;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            tagRd_q    <= '0;
            tagWr_q    <= '0;
            outCnt_q   <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspAddr_q  <= '0;
            errUnexp_q <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            tagRd_q    <= tagRd_d;
            tagWr_q    <= tagWr_d;
            outCnt_q   <= outCnt_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            rspAddr_q  <= rspAddr_d;
            errUnexp_q <= errUnexp_d;
        end
    end

endmodule

// File: tb/tb_mem_client_port.sv
// Directed self-checking bench for mem_client_port: inputs change and outputs are
// checked on the falling edge, with expected values worked out by hand.
module tb_mem_client_port;

    logic        clk;
    logic        rst_;
    logic        req_valid;
    logic        req_ready;
    logic [16:0] req_addr;
    logic [31:0] req_wrdata;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [16:0] rsp_addr;
    logic        arb_rts;
    logic        arb_rtr;
    logic [16:0] arb_addr;
    logic [31:0] arb_wrdata;
    logic [3:0]  arb_op;
    logic [31:0] bcast_data;
    logic [3:0]  bcast_xfc;
    logic        idle;
    logic        err_unexpected;

    int vecCount  = 0;
    int missCount = 0;

    mem_client_port #(
        .CLIENT_ID  (1),
        .NUM_CLIENTS(4),
        .FIFO_DEPTH (4),
        .MAX_OUT    (4)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wrdata    (req_wrdata),
        .req_op        (req_op),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_addr      (rsp_addr),
        .arb_rts       (arb_rts),
        .arb_rtr       (arb_rtr),
        .arb_addr      (arb_addr),
        .arb_wrdata    (arb_wrdata),
        .arb_op        (arb_op),
        .bcast_data    (bcast_data),
        .bcast_xfc     (bcast_xfc),
        .idle          (idle),
        .err_unexpected(err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle's inputs, lets the rising edge take them, returns on the falling edge.
    task automatic applyStimulus(input logic v, input logic [16:0] a, input logic [31:0] d,
                                 input logic [3:0] op, input logic rtr, input logic [3:0] xfc,
                                 input logic [31:0] bd);
        req_valid  = v;
        req_addr   = a;
        req_wrdata = d;
        req_op     = op;
        arb_rtr    = rtr;
        bcast_xfc  = xfc;
        bcast_data = bd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string phase);
        checkOutput({phase, "_arb_rts"},    32'(arb_rts),        32'd0);
        checkOutput({phase, "_arb_addr"},   32'(arb_addr),       32'd0);
        checkOutput({phase, "_arb_wrdata"}, arb_wrdata,          32'd0);
        checkOutput({phase, "_arb_op"},     32'(arb_op),         32'd0);
        checkOutput({phase, "_req_ready"},  32'(req_ready),      32'd1);
        checkOutput({phase, "_idle"},       32'(idle),           32'd1);
        checkOutput({phase, "_rsp_valid"},  32'(rsp_valid),      32'd0);
        checkOutput({phase, "_rsp_data"},   rsp_data,            32'd0);
        checkOutput({phase, "_rsp_addr"},   32'(rsp_addr),       32'd0);
        checkOutput({phase, "_err"},        32'(err_unexpected), 32'd0);
    endtask

    initial begin
        rst_       = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wrdata = '0;
        req_op     = '0;
        arb_rtr    = 1'b0;
        bcast_xfc  = '0;
        bcast_data = '0;
        #3;
        checkResetValues("rst");
        @(negedge clk);
        rst_ = 1'b1;

        // Single read: queued, transferred, answered four cycles later.
        applyStimulus(1, 17'h00123, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
        checkOutput("rd_rts_after_push", 32'(arb_rts),  32'd1);
        checkOutput("rd_arb_addr",       32'(arb_addr), 32'h00123);
        checkOutput("rd_idle_busy",      32'(idle),     32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("rd_rts_after_xfer", 32'(arb_rts),  32'd0);
        checkOutput("rd_idle_outst",     32'(idle),     32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
        checkOutput("rd_no_early_rsp",   32'(rsp_valid), 32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'hDEADBEEF);
        checkOutput("rd_rsp_valid",      32'(rsp_valid), 32'd1);
        checkOutput("rd_rsp_addr",       32'(rsp_addr),  32'h00123);
        checkOutput("rd_rsp_data",       rsp_data,       32'hDEADBEEF);
        checkOutput("rd_idle_done",      32'(idle),      32'd1);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
        checkOutput("rd_rsp_pulse_end",  32'(rsp_valid), 32'd0);

        // Full write: goes out, expects nothing back.
        applyStimulus(1, 17'h1FFFF, 32'hA5A5A5A5, 4'hF, 0, 4'b0000, 32'h0);
        checkOutput("wr_rts",        32'(arb_rts),  32'd1);
        checkOutput("wr_arb_addr",   32'(arb_addr), 32'h1FFFF);
        checkOutput("wr_arb_wrdata", arb_wrdata,    32'hA5A5A5A5);
        checkOutput("wr_arb_op",     32'(arb_op),   32'hF);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("wr_idle_after", 32'(idle),     32'd1);
        checkOutput("wr_rts_after",  32'(arb_rts),  32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
            checkOutput("wr_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Backpressure with queue wrap-around, using full writes.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 17'(32'h10 + i), 32'(32'h50000010 + i), 4'hF, 0, 4'b0000, 32'h0);
            checkOutput("bp_req_ready", 32'(req_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        checkOutput("bp_head_first", 32'(arb_addr), 32'h10);
        applyStimulus(1, 17'h14, 32'h50000014, 4'hF, 0, 4'b0000, 32'h0);
        checkOutput("bp_full_hold",  32'(req_ready), 32'd0);
        checkOutput("bp_head_stable", 32'(arb_addr), 32'h10);
        applyStimulus(1, 17'h14, 32'h50000014, 4'hF, 1, 4'b0000, 32'h0);
        checkOutput("bp_ready_again", 32'(req_ready), 32'd1);
        checkOutput("bp_order_11",    32'(arb_addr),  32'h11);
        applyStimulus(1, 17'h14, 32'h50000014, 4'hF, 1, 4'b0000, 32'h0);
        checkOutput("bp_order_12",    32'(arb_addr),  32'h12);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("bp_order_13",    32'(arb_addr),  32'h13);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("bp_order_14",    32'(arb_addr),  32'h14);
        checkOutput("bp_wrdata_14",   arb_wrdata,     32'h50000014);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("bp_drained_rts", 32'(arb_rts),   32'd0);
        checkOutput("bp_drained_idle", 32'(idle),     32'd1);

        // Outstanding limit: six reads, rtr always high, broadcasts held off.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 17'(32'h20 + i), 32'h0, 4'h0, 1, 4'b0000, 32'h0);
            checkOutput("lim_rts", 32'(arb_rts), (i < 4) ? 32'd1 : 32'd0);
        end
        checkOutput("lim_head",      32'(arb_addr),  32'h24);
        checkOutput("lim_req_ready", 32'(req_ready), 32'd1);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("lim_rts_held",  32'(arb_rts),   32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0010, 32'hD0000000);
        checkOutput("lim_rsp0_addr", 32'(rsp_addr),  32'h20);
        checkOutput("lim_rsp0_data", rsp_data,       32'hD0000000);
        checkOutput("lim_rts_back",  32'(arb_rts),   32'd1);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0010, 32'hD0000001);
        checkOutput("lim_rsp1_addr", 32'(rsp_addr),  32'h21);
        checkOutput("lim_rts_25",    32'(arb_rts),   32'd1);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0010, 32'hD0000002);
        checkOutput("lim_rsp2_addr", 32'(rsp_addr),  32'h22);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'hD0000003);
        checkOutput("lim_rsp3_addr", 32'(rsp_addr),  32'h23);
        checkOutput("lim_rsp3_data", rsp_data,       32'hD0000003);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
        checkOutput("lim_gap_valid", 32'(rsp_valid), 32'd0);
        checkOutput("lim_gap_idle",  32'(idle),      32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'hD0000004);
        checkOutput("lim_rsp4_addr", 32'(rsp_addr),  32'h24);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'hD0000005);
        checkOutput("lim_rsp5_addr", 32'(rsp_addr),  32'h25);
        checkOutput("lim_rsp5_data", rsp_data,       32'hD0000005);
        checkOutput("lim_idle",      32'(idle),      32'd1);

        // Transfer and response in the same cycle with two outstanding.
        applyStimulus(1, 17'h30, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        applyStimulus(1, 17'h31, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("sim_two_out_rts", 32'(arb_rts), 32'd0);
        applyStimulus(1, 17'h32, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("sim_rts_32",      32'(arb_rts), 32'd1);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0010, 32'hB0000000);
        checkOutput("sim_rsp30_addr",  32'(rsp_addr), 32'h30);
        checkOutput("sim_rsp30_data",  rsp_data,      32'hB0000000);
        checkOutput("sim_empty_rts",   32'(arb_rts),  32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'hB0000001);
        checkOutput("sim_rsp31_addr",  32'(rsp_addr), 32'h31);
        checkOutput("sim_still_busy",  32'(idle),     32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'hB0000002);
        checkOutput("sim_rsp32_addr",  32'(rsp_addr), 32'h32);
        checkOutput("sim_idle",        32'(idle),     32'd1);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
        checkOutput("sim_no_err",      32'(err_unexpected), 32'd0);

        // Other clients' broadcast bits are ignored; this client's bit while idle is flagged.
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b1101, 32'h11111111);
        checkOutput("oth_no_err",      32'(err_unexpected), 32'd0);
        checkOutput("oth_no_rsp",      32'(rsp_valid),      32'd0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'h22222222);
        checkOutput("spur_err",        32'(err_unexpected), 32'd1);
        checkOutput("spur_no_rsp",     32'(rsp_valid),      32'd0);
        checkOutput("spur_data_drop",  rsp_data,            32'hB0000002);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0000, 32'h0);
        checkOutput("spur_sticky",     32'(err_unexpected), 32'd1);

        // Reset in the middle of a burst with two reads in flight.
        applyStimulus(1, 17'h40, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        applyStimulus(1, 17'h41, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 1, 4'b0000, 32'h0);
        checkOutput("mid_busy",        32'(idle), 32'd0);
        req_valid = 1'b0;
        arb_rtr   = 1'b0;
        rst_      = 1'b0;
        #1;
        checkResetValues("mid");
        @(negedge clk);
        rst_ = 1'b1;
        applyStimulus(0, 17'h0, 32'h0, 4'h0, 0, 4'b0010, 32'h33333333);
        checkOutput("post_rst_err",    32'(err_unexpected), 32'd1);
        checkOutput("post_rst_no_rsp", 32'(rsp_valid),      32'd0);
        checkOutput("post_rst_idle",   32'(idle),           32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
